// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial line, strobe, holding-register handshake and error reporting of serial_frame_rx.
interface serial_frame_rx_if #(parameter int DATA_W = 8);
  logic              I_SERIAL_DATA;
  logic              I_BIT_VLD;
  logic [DATA_W-1:0] O_DATA;
  logic              O_VALID;
  logic              I_READY;
  logic              O_ERROR;
  logic [2:0]        O_ERR_CODE;
  logic [7:0]        O_ERR_CNT;
  logic              I_CNT_CLR;
  modport master (
    input  I_SERIAL_DATA, I_BIT_VLD, I_READY, I_CNT_CLR,
    output O_DATA, O_VALID, O_ERROR, O_ERR_CODE, O_ERR_CNT
  );
  modport slave (
    output I_SERIAL_DATA, I_BIT_VLD, I_READY, I_CNT_CLR,
    input  O_DATA, O_VALID, O_ERROR, O_ERR_CODE, O_ERR_CNT
  );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: strobe-sampled start/data/parity/stop deserialiser with a one-entry holding register and error reporting.
module serial_frame_rx #(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter bit LSB_FIRST   = 1
) (
  input logic clk,
  input logic rstn,
  serial_frame_rx_if.master bus
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK_WAIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] sh, sh_nx, data;
  logic par, par_nx, perr, perr_nx, ferr, ferr_nx, valid, error;
  logic [2:0] code;
  logic [7:0] err_cnt;
  logic ln, done, bad, load, ovr;
  assign ln   = bus.I_SERIAL_DATA;
  assign done = bus.I_BIT_VLD && state == STOP && (STOP_BITS == 1 || cnt[0]);
  assign bad  = perr | ferr | ~ln;
  assign load = done & ~bad & (~valid | bus.I_READY);
  assign ovr  = done & ~bad & valid & ~bus.I_READY;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    par_nx   = par;
    perr_nx  = perr;
    ferr_nx  = ferr;
    if (bus.I_BIT_VLD)
      case (state)
        IDLE: if (!ln) begin
          state_nx = DATA;
          cnt_nx   = '0;
          par_nx   = 1'b0;
          perr_nx  = 1'b0;
          ferr_nx  = 1'b0;
        end
        DATA: begin
          sh_nx  = LSB_FIRST ? {ln, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], ln};
          par_nx = par ^ ln;
          cnt_nx = cnt == CW'(DATA_W - 1) ? '0 : cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) state_nx = PARITY_MODE != 0 ? PARITY : STOP;
        end
        PARITY: begin
          perr_nx  = ln != (PARITY_MODE == 1 ? par : ~par);
          state_nx = STOP;
        end
        STOP: begin
          ferr_nx = ferr | ~ln;
          cnt_nx  = cnt + 1'b1;
          // a low final stop means the line may be in break; wait for it to rise
          if (done) state_nx = ln ? IDLE : BREAK_WAIT;
        end
        BREAK_WAIT: if (ln) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      par     <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      data    <= '0;
      valid   <= 1'b0;
      error   <= 1'b0;
      code    <= 3'b000;
      err_cnt <= 8'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      sh      <= sh_nx;
      par     <= par_nx;
      perr    <= perr_nx;
      ferr    <= ferr_nx;
      data    <= load ? sh : data;
      valid   <= load | (valid & ~bus.I_READY);
      error   <= done & ~load;
      code    <= done & ~load ? {ovr, ferr | ~ln, perr} : 3'b000;
      err_cnt <= bus.I_CNT_CLR ? 8'd0 : (done & ~load & ~&err_cnt) ? err_cnt + 8'd1 : err_cnt;
    end
  assign bus.O_DATA     = data;
  assign bus.O_VALID    = valid;
  assign bus.O_ERROR    = error;
  assign bus.O_ERR_CODE = code;
  assign bus.O_ERR_CNT  = err_cnt;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames into a default receiver and a 7-bit/odd/2-stop/MSB-first receiver.
module tb_serial_frame_rx;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic line = 1'b1;
  logic vld = 1'b0;
  logic sel = 1'b0;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  serial_frame_rx_if #(.DATA_W(8)) b8 ();
  serial_frame_rx_if #(.DATA_W(7)) b7 ();
  assign b8.I_SERIAL_DATA = line;
  assign b7.I_SERIAL_DATA = line;
  assign b8.I_BIT_VLD = vld & ~sel;
  assign b7.I_BIT_VLD = vld & sel;
  serial_frame_rx #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .LSB_FIRST(1)) dut8 (.clk(clk), .rstn(rstn), .bus(b8));
  serial_frame_rx #(.DATA_W(7), .PARITY_MODE(2), .STOP_BITS(2), .LSB_FIRST(0)) dut7 (.clk(clk), .rstn(rstn), .bus(b7));
  task automatic send(input logic b, input int gap);
    vld = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    line = b;
    vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
  endtask
  // sel picks the DUT; pflip corrupts parity; stopv[i] is stop bit i; rl raises b8 ready before the last stop
  task automatic frame(input logic [15:0] d, input logic pflip, input logic [1:0] stopv, input int gap, input logic rl);
    int dw;
    logic p;
    dw = sel ? 7 : 8;
    send(1'b0, gap);
    for (int i = 0; i < dw; i++) send(sel ? d[dw-1-i] : d[i], gap);
    p = (^(d & ((16'h1 << dw) - 16'h1))) ^ sel ^ pflip;
    send(p, gap);
    if (sel) send(stopv[0], gap);
    if (rl) b8.I_READY = 1'b1;
    send(stopv[sel], gap);
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (b8.O_DATA !== 8'h00) begin errs++; $display("FAIL rst_data: got %h want 00", b8.O_DATA); end
    checks++; if (b8.O_VALID !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", b8.O_VALID); end
    checks++; if (b8.O_ERROR !== 1'b0) begin errs++; $display("FAIL rst_error: got %b want 0", b8.O_ERROR); end
    checks++; if (b8.O_ERR_CODE !== 3'b000) begin errs++; $display("FAIL rst_code: got %b want 000", b8.O_ERR_CODE); end
    checks++; if (b8.O_ERR_CNT !== 8'd0) begin errs++; $display("FAIL rst_cnt: got %0d want 0", b8.O_ERR_CNT); end
    checks++; if (b7.O_VALID !== 1'b0) begin errs++; $display("FAIL rst_valid7: got %b want 0", b7.O_VALID); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_good;
    frame(16'hA5, 1'b0, 2'b11, 0, 1'b0);
    checks++; if (b8.O_VALID !== 1'b1) begin errs++; $display("FAIL good_valid: got %b want 1", b8.O_VALID); end
    checks++; if (b8.O_DATA !== 8'hA5) begin errs++; $display("FAIL good_data: got %h want a5", b8.O_DATA); end
    checks++; if (b8.O_ERROR !== 1'b0) begin errs++; $display("FAIL good_error: got %b want 0", b8.O_ERROR); end
    b8.I_READY = 1'b1;
    @(posedge clk); #1;
    b8.I_READY = 1'b0;
    checks++; if (b8.O_VALID !== 1'b0) begin errs++; $display("FAIL good_dequeue: got %b want 0", b8.O_VALID); end
  endtask
  task automatic test_parity;
    frame(16'hA5, 1'b1, 2'b11, 0, 1'b0);
    checks++; if (b8.O_ERROR !== 1'b1) begin errs++; $display("FAIL par_error: got %b want 1", b8.O_ERROR); end
    checks++; if (b8.O_ERR_CODE !== 3'b001) begin errs++; $display("FAIL par_code: got %b want 001", b8.O_ERR_CODE); end
    checks++; if (b8.O_VALID !== 1'b0) begin errs++; $display("FAIL par_valid: got %b want 0", b8.O_VALID); end
    checks++; if (b8.O_ERR_CNT !== 8'd1) begin errs++; $display("FAIL par_cnt: got %0d want 1", b8.O_ERR_CNT); end
    @(posedge clk); #1;
    checks++; if ({b8.O_ERROR, b8.O_ERR_CODE} !== 4'b0000) begin errs++; $display("FAIL par_pulse: got %b want 0000", {b8.O_ERROR, b8.O_ERR_CODE}); end
  endtask
  task automatic test_break;
    frame(16'hFF, 1'b0, 2'b00, 0, 1'b0);
    checks++; if (b8.O_ERR_CODE !== 3'b010) begin errs++; $display("FAIL brk_code: got %b want 010", b8.O_ERR_CODE); end
    checks++; if (b8.O_ERR_CNT !== 8'd2) begin errs++; $display("FAIL brk_cnt: got %0d want 2", b8.O_ERR_CNT); end
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 0);
      checks++; if ({b8.O_VALID, b8.O_ERROR} !== 2'b00) begin errs++; $display("FAIL brk_low%0d: got %b want 00", i, {b8.O_VALID, b8.O_ERROR}); end
    end
    send(1'b1, 0);
    frame(16'h3C, 1'b0, 2'b11, 0, 1'b0);
    checks++; if (b8.O_VALID !== 1'b1) begin errs++; $display("FAIL brk_valid: got %b want 1", b8.O_VALID); end
    checks++; if (b8.O_DATA !== 8'h3C) begin errs++; $display("FAIL brk_data: got %h want 3c", b8.O_DATA); end
    b8.I_READY = 1'b1;
    @(posedge clk); #1;
    b8.I_READY = 1'b0;
  endtask
  task automatic test_back_to_back;
    frame(16'h11, 1'b0, 2'b11, 0, 1'b0);
    checks++; if (b8.O_DATA !== 8'h11) begin errs++; $display("FAIL b2b_first: got %h want 11", b8.O_DATA); end
    frame(16'h22, 1'b0, 2'b11, 0, 1'b0);
    checks++; if (b8.O_ERROR !== 1'b1) begin errs++; $display("FAIL b2b_error: got %b want 1", b8.O_ERROR); end
    checks++; if (b8.O_ERR_CODE !== 3'b100) begin errs++; $display("FAIL b2b_code: got %b want 100", b8.O_ERR_CODE); end
    checks++; if (b8.O_DATA !== 8'h11) begin errs++; $display("FAIL b2b_keep: got %h want 11", b8.O_DATA); end
    checks++; if (b8.O_ERR_CNT !== 8'd3) begin errs++; $display("FAIL b2b_cnt: got %0d want 3", b8.O_ERR_CNT); end
    frame(16'h33, 1'b0, 2'b11, 0, 1'b1);
    checks++; if (b8.O_VALID !== 1'b1) begin errs++; $display("FAIL b2b_valid: got %b want 1", b8.O_VALID); end
    checks++; if (b8.O_DATA !== 8'h33) begin errs++; $display("FAIL b2b_data: got %h want 33", b8.O_DATA); end
    checks++; if (b8.O_ERROR !== 1'b0) begin errs++; $display("FAIL b2b_noerr: got %b want 0", b8.O_ERROR); end
    @(posedge clk); #1;
    b8.I_READY = 1'b0;
    checks++; if (b8.O_VALID !== 1'b0) begin errs++; $display("FAIL b2b_drain: got %b want 0", b8.O_VALID); end
  endtask
  task automatic test_slow_reset;
    send(1'b0, 15);
    for (int i = 0; i < 4; i++) send(1'b1, 15);
    repeat (7) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checks++; if ({b8.O_VALID, b8.O_ERROR, b8.O_ERR_CODE} !== 5'b0) begin errs++; $display("FAIL srst_flags: got %b want 00000", {b8.O_VALID, b8.O_ERROR, b8.O_ERR_CODE}); end
    checks++; if (b8.O_ERR_CNT !== 8'd0) begin errs++; $display("FAIL srst_cnt: got %0d want 0", b8.O_ERR_CNT); end
    checks++; if (b8.O_DATA !== 8'h00) begin errs++; $display("FAIL srst_data: got %h want 00", b8.O_DATA); end
    @(posedge clk); #1;
    send(1'b0, 3);
    rstn = 1'b1;
    frame(16'h5A, 1'b0, 2'b11, 15, 1'b0);
    checks++; if (b8.O_VALID !== 1'b1) begin errs++; $display("FAIL srst_valid: got %b want 1", b8.O_VALID); end
    checks++; if (b8.O_DATA !== 8'h5A) begin errs++; $display("FAIL srst_rxdata: got %h want 5a", b8.O_DATA); end
    checks++; if ({b8.O_ERROR, b8.O_ERR_CNT} !== 9'd0) begin errs++; $display("FAIL srst_noerr: got %h want 000", {b8.O_ERROR, b8.O_ERR_CNT}); end
  endtask
  task automatic test_param7;
    sel = 1'b1;
    frame(16'h55, 1'b0, 2'b11, 0, 1'b0);
    checks++; if (b7.O_VALID !== 1'b1) begin errs++; $display("FAIL p7_valid: got %b want 1", b7.O_VALID); end
    checks++; if (b7.O_DATA !== 7'h55) begin errs++; $display("FAIL p7_data: got %h want 55", b7.O_DATA); end
    frame(16'h2A, 1'b0, 2'b01, 0, 1'b0);
    checks++; if (b7.O_ERR_CODE !== 3'b010) begin errs++; $display("FAIL p7_code: got %b want 010", b7.O_ERR_CODE); end
    checks++; if (b7.O_ERR_CNT !== 8'd1) begin errs++; $display("FAIL p7_cnt1: got %0d want 1", b7.O_ERR_CNT); end
    send(1'b1, 0);
    for (int i = 1; i < 300; i++) begin
      frame(16'h2A, 1'b0, 2'b01, 0, 1'b0);
      send(1'b1, 0);
    end
    checks++; if (b7.O_ERR_CNT !== 8'd255) begin errs++; $display("FAIL p7_sat: got %0d want 255", b7.O_ERR_CNT); end
    checks++; if (b7.O_DATA !== 7'h55) begin errs++; $display("FAIL p7_keep: got %h want 55", b7.O_DATA); end
    b7.I_CNT_CLR = 1'b1;
    @(posedge clk); #1;
    b7.I_CNT_CLR = 1'b0;
    checks++; if (b7.O_ERR_CNT !== 8'd0) begin errs++; $display("FAIL p7_clr: got %0d want 0", b7.O_ERR_CNT); end
    sel = 1'b0;
  endtask
  initial begin
    b8.I_READY = 1'b0;
    b8.I_CNT_CLR = 1'b0;
    b7.I_READY = 1'b0;
    b7.I_CNT_CLR = 1'b0;
    test_reset;
    test_good;
    test_parity;
    test_break;
    test_back_to_back;
    test_slow_reset;
    test_param7;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Parametrised serial frame receiver: deserialises start / DATA_W data / optional parity / 1–2 stop-bit frames sampled on an external bit strobe. Parity and framing are checked, good frames are buffered in a one-entry valid/ready holding register, and every bad or overrun frame is discarded and reported with a cause code. It sits between a baud/bit-strobe generator and a byte-stream consumer, and is the general-purpose successor to the fixed 8-bit even-parity receiver.

## Interface

Parameters:

- DATA_W, 8, data bits per frame (5–16).
- PARITY_MODE, 1, selects the parity check:
  - 0: no parity bit.
  - 1: even; expected parity bit = ^data.
  - 2: odd; expected parity bit = ~^data.
- STOP_BITS, 1, number of stop bits (1 or 2).
- LSB_FIRST, 1, first data bit received is data[0] when 1; data[DATA_W-1] when 0.

Ports:

- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  asynchronous, active-low reset.
- I_SERIAL_DATA  in  1  serial line; idles high, start bit = 0, stop bit = 1.
- I_BIT_VLD  in  1  one-cycle sample strobe, one per bit period; the line is sampled only when this is high.
- O_DATA  out  DATA_W  holding-register contents; stable while O_VALID=1.
- O_VALID  out  1  holding register full.
- I_READY  in  1  consumer accepts O_DATA when O_VALID && I_READY.
- O_ERROR  out  1  one-cycle pulse per discarded frame.
- O_ERR_CODE  out  3  {overrun, frame, parity}; valid only while O_ERROR=1, otherwise 0.
- O_ERR_CNT  out  8  saturating count of discarded frames.
- I_CNT_CLR  in  1  synchronous clear of O_ERR_CNT.

## Operation

- FSM states: IDLE, DATA, PARITY, STOP, BREAK_WAIT. Transitions occur only on cycles with I_BIT_VLD=1.
- IDLE:
  - line=0 → DATA; the bit counter and running parity are cleared.
  - line=1 → stay in IDLE.
- DATA:
  - Shift in one bit per strobe. The shift direction is set by LSB_FIRST.
  - Running parity ^= bit.
  - After DATA_W bits, go to PARITY (PARITY_MODE≠0) or STOP.
- PARITY: on one strobe, compare the line against the expected parity and latch a parity-error flag, then go to STOP.
- STOP:
  - Sample STOP_BITS strobes; any 0 latches the frame-error flag.
  - On the last stop strobe the result is produced (see below). Next state is IDLE, or BREAK_WAIT if the final stop sample was 0.
- BREAK_WAIT: stay until a strobe samples line=1, then go to IDLE. This prevents a held-low line (break) from being decoded as a new start bit.
- Result, evaluated on the last-stop-strobe edge:
  - Parity or frame error: O_ERROR pulse with the parity/frame bits set. The data is discarded and the holding register is unchanged.
  - Otherwise, holding register empty (or being dequeued in this same cycle by I_READY): load O_DATA and set O_VALID.
  - Otherwise (holding register full, not dequeued): O_ERROR pulse with code 3'b100. The new data is discarded and O_DATA keeps the old value.
  - Overrun is reported only for frames that are otherwise good; parity and frame errors take precedence, and both bits may be set together.
- Handshake: O_VALID falls on the edge where O_VALID && I_READY, unless a new good frame loads on the same edge, in which case O_VALID stays 1 with the new data.
- O_ERR_CNT:
  - +1 on each O_ERROR pulse, saturating at 255.
  - I_CNT_CLR takes priority; if an error occurs in the same cycle as a clear, the counter still ends at 0.
- I_BIT_VLD is ignored while rstn=0. Strobes may be separated by any number (≥0) of idle cycles; behaviour depends only on the sequence of strobed samples.

## Timing

- Reset (rstn=0, asynchronous): state=IDLE, O_DATA=0, O_VALID=0, O_ERROR=0, O_ERR_CODE=0, O_ERR_CNT=0; any partial frame is lost.
- Reset release is synchronous in effect: the first strobe after release is evaluated from IDLE.
- Latency: O_VALID or O_ERROR is asserted in the cycle after the cycle carrying the last stop-bit strobe.
- O_ERROR and O_ERR_CODE are high for exactly one cycle.
- Frame length = 1 + DATA_W + (PARITY_MODE≠0) + STOP_BITS strobes. Back-to-back frames are allowed: a start bit may arrive on the strobe immediately after the last stop strobe.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Defaults, continuous strobe, frame 0xA5: line 0,1,0,1,0,0,1,0,1,0(parity),1(stop) → O_VALID=1 with O_DATA=8'hA5 one cycle after the stop strobe; no O_ERROR.
- Same frame with parity bit 1 → O_ERROR pulse, O_ERR_CODE=3'b001, O_VALID stays 0, O_ERR_CNT=1.
- Stop bit 0, then the line held low for 5 strobes, then high, then frame 0x3C:
  - O_ERR_CODE=3'b010.
  - No spurious start while held low.
  - 0x3C is then received correctly.
- I_READY=0; back-to-back frames 0x11 and 0x22:
  - Second frame gives O_ERR_CODE=3'b100 and O_DATA stays 8'h11.
  - Then I_READY=1 with frame 0x33 completing on the dequeue edge → O_VALID stays 1 with O_DATA=8'h33.
- I_BIT_VLD once every 16 cycles; rstn pulsed low after 4 data bits; then a full frame 0x5A → no output from the aborted frame, 0x5A received; all outputs 0 during reset.
- DATA_W=7, PARITY_MODE=2, STOP_BITS=2, LSB_FIRST=0:
  - Frame 7'h55 with parity 1 → O_DATA=7'h55.
  - Second stop bit 0 → O_ERR_CODE=3'b010.
  - 300 such errors → O_ERR_CNT=255.
  - I_CNT_CLR → 0.
